wheel_drive_ramp: RTL
=====================

Name: wheel_drive_ramp

Overview:
Two-wheel drive controller for the robot chassis and the next generation of the on/off wheel enable block. It accepts a drive command (steering mode, speed, direction) through a valid/ready handshake. It ramps each wheel's PWM duty toward its target at a programmable rate and makes direction reversals safe by decelerating to zero first. It sits between the navigation FSM and the motor driver pins; an emergency stop input overrides everything.

Parameters:
- PWM_BITS, 8: duty/counter width. DMAX = 2^PWM_BITS-1; PWM period = DMAX clk cycles.
- RAMP_DIV, 1000: clk cycles between ramp ticks (>=1).
- RAMP_STEP, 4: duty change per ramp tick (1..DMAX).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at posedge clk
- cmd_state  in  2  00 both wheels, 01 left only, 10 right only, 11 stop
- cmd_speed  in  PWM_BITS  target duty for active wheels
- cmd_reverse  in  1  1 = reverse both wheels
- estop  in  1  level emergency stop
- right  out  1  right wheel PWM
- left  out  1  left wheel PWM
- dir_right  out  1  right direction, 1 = reverse
- dir_left  out  1  left direction, 1 = reverse
- busy  out  1  ramp or reversal in progress

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n). All state is cleared on rst_n low regardless of clk.
- Reset values: right=0, left=0, dir_right=0, dir_left=0, busy=0; duties, targets, PWM counter and prescaler all 0; FSM=IDLE. cmd_ready=1 in reset when estop=0.
- cmd_ready = (FSM==IDLE) & ~estop. It is decoded combinationally from registered state, not from cmd_valid.
- On accept, target duties are latched:
  - tgt_r = cmd_speed if cmd_state in {00,10}, else 0.
  - tgt_l = cmd_speed if cmd_state in {00,01}, else 0.
  - req_dir = cmd_reverse.
  - The prescaler restarts; the first ramp tick comes exactly RAMP_DIV cycles after the accept edge.
- FSM states:
  - IDLE: duties equal targets and dir equals req_dir. busy=0. On accept: go to BRAKE if req_dir != current dir and any duty != 0; otherwise go to RAMP. If nothing differs, stay IDLE (no-op accept).
  - RAMP: on each tick, each duty moves toward its target by RAMP_STEP, saturating at the target (never overshoot). No wrap; arithmetic is 1 bit wider than PWM_BITS. When both duties equal targets, go to IDLE.
  - BRAKE: on each tick, duties move toward 0 by RAMP_STEP. When both are 0, dir_right and dir_left take req_dir in the same cycle, then go to RAMP.
  - ESTOP: entered from any state on the first clk edge with estop=1. Duties, targets and prescaler are forced to 0; right=left=0 combinationally from estop; dir is held. Leave to IDLE on the first edge with estop=0.
- Direction change when duties are already 0: dir updates on the cycle after accept, then RAMP.
- dir_* changes only while both effective duties and both PWM outputs are 0.
- PWM:
  - Free-running counter 0..DMAX-1, wraps to 0.
  - Output = (cnt < eff_duty), so duty 0 gives constant low and DMAX gives constant high.
  - eff_duty is loaded from the ramping duty only when cnt==0, so no mid-period glitches. Exception: estop forces the output low immediately.
- busy = FSM in {RAMP, BRAKE}.
- cmd_valid while not ready: the command is ignored, and the source must hold it.
- estop and cmd_valid asserted in the same cycle: estop wins, and the command is not accepted.

Decomposition:
- Shared package (wheel_pkg):
  - cmd_state encodings: DRV_BOTH=2'b00, DRV_LEFT=2'b01, DRV_RIGHT=2'b10, DRV_STOP=2'b11.
  - FSM state constants: IDLE, RAMP, BRAKE, ESTOP.
- Natural sub-module: wheel_pwm_ch, instantiated twice. It holds the duty ramp register, eff_duty load at cnt==0 and the comparator. The top level owns the FSM, prescaler, shared PWM counter and direction registers.

Test Plan (bench params PWM_BITS=4, DMAX=15, RAMP_DIV=2, RAMP_STEP=5):
- Reset then accept {00, speed 15, fwd} -> duties 5,10,15 at ticks 2,4,6 cycles after accept. busy drops and cmd_ready rises after the 15 step. right=left=1 for all 15 counts of the next period.
- From both at 15, send {01, 7} -> right ramps 15,10,5,0 and left ramps 15,10,7. Left PWM is high 7 of 15 cycles per period.
- From both at 10 fwd, send {00, 10, reverse} -> BRAKE to 0, then dir_right=dir_left=1 at the zero point, then ramp 5,10. Check the PWM outputs are low on every cycle where dir_* toggles.
- Assert estop mid-ramp at duty 5 -> right=left=0 the same cycle and cmd_ready=0. Release -> IDLE with duty 0, dir held, cmd_ready=1.
- Pulse rst_n low asynchronously mid-PWM-period -> all outputs 0 immediately, without a clk edge.
- Hold cmd_valid during RAMP -> no accept until IDLE, then the held command is accepted exactly once.

Source files
------------

// File: rtl/wheel_drive_ramp_pkg.sv
// Shared definitions for the two-wheel drive ramp controller.
//   cmd_state encodings, FSM state type, and wheel-select helpers.
package wheel_pkg;

  localparam logic [1:0] DRV_BOTH  = 2'b00;
  localparam logic [1:0] DRV_LEFT  = 2'b01;
  localparam logic [1:0] DRV_RIGHT = 2'b10;
  localparam logic [1:0] DRV_STOP  = 2'b11;

  typedef enum logic [1:0] {IDLE, RAMP, BRAKE, ESTOP} fsm_t;

  function automatic logic drives_right(input logic [1:0] s);
    return (s == DRV_BOTH) || (s == DRV_RIGHT);
  endfunction

  function automatic logic drives_left(input logic [1:0] s);
    return (s == DRV_BOTH) || (s == DRV_LEFT);
  endfunction

endpackage

// File: rtl/wheel_drive_ramp_pwm_ch.sv
// One wheel channel: ramping duty register, period-aligned effective duty,
// and the PWM comparator.
//   clr      - synchronous clear of duty and effective duty (emergency stop)
//   step     - move duty one RAMP_STEP toward goal this cycle
//   goal     - ramp destination
//   wrap     - shared counter is at its last count; eff_duty reloads here
//   cnt      - shared PWM counter
//   estop    - forces pwm low combinationally
//   duty     - current ramp duty
//   at_goal  - duty after this cycle's step equals goal
//   zero     - duty and effective duty both 0 (output is quiet)
//   pwm      - PWM output
module wheel_pwm_ch #(
  parameter int PWM_BITS  = 8,
  parameter int RAMP_STEP = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                step,
  input  logic [PWM_BITS-1:0] goal,
  input  logic                wrap,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic                estop,
  output logic [PWM_BITS-1:0] duty,
  output logic                at_goal,
  output logic                zero,
  output logic                pwm
);
  localparam int W1 = PWM_BITS + 1;

  logic [PWM_BITS-1:0] eff, nxt;
  logic [W1-1:0]       d_w, g_w, stp_w, up, dn;

  // One extra bit keeps up-steps from wrapping past DMAX.
  assign d_w   = {1'b0, duty};
  assign g_w   = {1'b0, goal};
  assign stp_w = W1'(RAMP_STEP);
  assign up    = d_w + stp_w;
  assign dn    = d_w - stp_w;

  always_comb begin
    nxt = duty;
    if (step) begin
      if (d_w < g_w)      nxt = (up >= g_w) ? goal : up[PWM_BITS-1:0];
      else if (d_w > g_w) nxt = (d_w >= g_w + stp_w) ? dn[PWM_BITS-1:0] : goal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= '0;
      eff  <= '0;
    end else if (clr) begin
      duty <= '0;
      eff  <= '0;
    end else begin
      duty <= nxt;
      // Latched on the wrap edge so a whole period (cnt 0..DMAX-1) sees one value.
      if (wrap) eff <= duty;
    end
  end

  assign at_goal = (nxt == goal);
  assign zero    = (duty == '0) && (eff == '0);
  assign pwm     = ~estop & (cnt < eff);

endmodule

// File: rtl/wheel_drive_ramp.sv
// Two-wheel drive controller: accepts {state, speed, reverse} commands on a
// valid/ready handshake, ramps each wheel's PWM duty at RAMP_STEP per
// RAMP_DIV cycles, brakes to zero before any direction reversal, and
// yields to a level emergency stop.
//   cmd_valid/cmd_ready - command handshake; ready only when idle and not stopped
//   cmd_state/speed/reverse - wheel select, target duty, direction
//   estop     - emergency stop, outputs low immediately
//   right/left - wheel PWM outputs
//   dir_right/dir_left - direction outputs, 1 = reverse
//   busy      - ramp or brake in progress
module wheel_drive_ramp
  import wheel_pkg::*;
#(
  parameter int PWM_BITS  = 8,
  parameter int RAMP_DIV  = 1000,
  parameter int RAMP_STEP = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_state,
  input  logic [PWM_BITS-1:0] cmd_speed,
  input  logic                cmd_reverse,
  input  logic                estop,
  output logic                right,
  output logic                left,
  output logic                dir_right,
  output logic                dir_left,
  output logic                busy
);
  localparam int NCH  = 2;  // index 0 = right, 1 = left
  localparam int DMAX = 2**PWM_BITS - 1;
  localparam int PW   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  fsm_t                          st;
  logic [PWM_BITS-1:0]           cnt;
  logic [PW-1:0]                 presc;
  logic [NCH-1:0][PWM_BITS-1:0]  tgt, goal, duty, nt;
  logic [NCH-1:0]                at_goal, zero, pwm;
  logic                          dir, req_dir, accept, tick, wrap, step;

  assign cmd_ready = (st == IDLE) & ~estop;
  assign accept    = cmd_valid & cmd_ready;
  assign tick      = (presc == PW'(RAMP_DIV - 1));
  assign wrap      = (cnt == PWM_BITS'(DMAX - 1));
  assign step      = tick & ((st == RAMP) | (st == BRAKE));
  assign goal      = (st == BRAKE) ? '0 : tgt;
  assign busy      = (st == RAMP) | (st == BRAKE);

  always_comb begin
    nt[0] = drives_right(cmd_state) ? cmd_speed : '0;
    nt[1] = drives_left(cmd_state)  ? cmd_speed : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= wrap ? '0 : cnt + PWM_BITS'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      tgt     <= '0;
      presc   <= '0;
      dir     <= 1'b0;
      req_dir <= 1'b0;
    end else if (estop) begin
      st    <= ESTOP;
      tgt   <= '0;
      presc <= '0;
    end else begin
      // Restart on accept so the first tick lands RAMP_DIV cycles later.
      presc <= (accept || tick) ? '0 : presc + PW'(1);
      case (st)
        IDLE: if (accept) begin
          tgt     <= nt;
          req_dir <= cmd_reverse;
          // A reversal always passes through BRAKE; with duties already at
          // zero it only waits for the outputs to be quiet, then flips.
          if (cmd_reverse != dir) st <= BRAKE;
          else if (nt != duty)    st <= RAMP;
        end
        RAMP:  if (&at_goal) st <= IDLE;
        BRAKE: if (&zero) begin
          dir <= req_dir;
          st  <= RAMP;
        end
        ESTOP: st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    wheel_pwm_ch #(.PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (estop),
      .step    (step),
      .goal    (goal[i]),
      .wrap    (wrap),
      .cnt     (cnt),
      .estop   (estop),
      .duty    (duty[i]),
      .at_goal (at_goal[i]),
      .zero    (zero[i]),
      .pwm     (pwm[i])
    );
  end

  assign right     = pwm[0];
  assign left      = pwm[1];
  assign dir_right = dir;
  assign dir_left  = dir;

endmodule
